tree_reduce_sequencer: RTL

- Sequences the existing 8-lane, float32, pipelined tree adder so it can sum a row of up to 64 words.
- Rows stream in as 8-word chunks; each chunk's partial sum is buffered.
- A final fold pass sends the buffered partials back through the same tree.
- Sits between the row-fetch logic and the tree adder, and owns the tree's inputs exclusively.

---
 rtl/tree_reduce_pkg.sv | 32 +++
 rtl/reduce_valid_pipe.sv | 35 +++
 rtl/tree_reduce_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tree_reduce_pkg.sv
// tree_reduce_pkg
// Shared constants, state encoding and helpers for the tree reduce sequencer
// and any other block that drives the 8-lane float32 tree adder.
//   WORD_W       float32 word width
//   LANES        tree width in words
//   MAX_CHUNKS   partial-sum buffer depth (<= LANES so one fold pass suffices)
//   FP_ZERO      +0.0, used as lane padding
package tree_reduce_pkg;

    localparam int WORD_W     = 32;
    localparam int LANES      = 8;
    localparam int MAX_CHUNKS = 8;

    localparam logic [WORD_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_FOLD,
        ST_FOLD_WAIT,
        ST_DONE
    } state_e;

    // Requests above the buffer depth are clamped rather than rejected.
    function automatic logic [3:0] clamp_chunks(input logic [3:0] req);
        if (req > 4'(MAX_CHUNKS)) begin
            return 4'(MAX_CHUNKS);
        end
        return req;
    endfunction

endpackage

// File: rtl/reduce_valid_pipe.sv
// reduce_valid_pipe
// DEPTH-deep 1-bit shift register that tracks which tree_sum cycles carry a
// result. Cleared asynchronously so in-flight results are dropped on reset.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high clear
//   in_bit   1 when the tree inputs this cycle carry real data
//   out_bit  1 when the matching tree_sum is valid (DEPTH cycles later)
module reduce_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    output logic out_bit
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    always_comb begin
        shift_d = (shift_q << 1) | DEPTH'(in_bit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out_bit = shift_q[DEPTH-1];

endmodule

// File: rtl/tree_reduce_sequencer.sv
// tree_reduce_sequencer
// Streams a row of up to 8 chunks (8 float32 words each) through the shared
// pipelined tree adder, buffers each chunk's partial sum, then sends the
// partials back through the tree once to form the row sum.
// Optional macro TREE_REDUCE_PERF_EN enables the perf_cycles counter;
// without it perf_cycles is tied to 0.
// Ports:
//   clk, rst               clock, async active-high reset
//   start, num_chunks      row request (sampled in IDLE only)
//   in_valid/in_ready      chunk handshake, in_data = 8 words, lane0 = [31:0]
//   tree_in / tree_sum     tree adder inputs / summation (TREE_LAT later)
//   busy                   high whenever not IDLE
//   out_valid/out_ready    row sum handshake, out_sum = float32 row sum
//   perf_cycles            start-to-first-out_valid cycle count
//
// state      | meaning
// IDLE       | waiting for start with num_chunks != 0
// FEED       | accepting chunks, collecting partial sums
// FOLD       | one cycle driving buffered partials into the tree
// FOLD_WAIT  | waiting for the fold result
// DONE       | out_valid held until out_ready
module tree_reduce_sequencer
    import tree_reduce_pkg::*;
#(
    parameter int TREE_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   num_chunks,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    output logic [255:0] tree_in,
    input  logic [31:0]  tree_sum,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_sum,
    output logic [15:0]  perf_cycles
);

    state_e state_q, state_d;

    logic [3:0]        n_q, n_d;
    logic [3:0]        issued_q, issued_d;
    logic [3:0]        received_q, received_d;
    logic [2:0]        wr_ptr_q, wr_ptr_d;
    logic [WORD_W-1:0] pbuf_q [MAX_CHUNKS];
    logic [WORD_W-1:0] pbuf_d [MAX_CHUNKS];
    logic [WORD_W-1:0] out_sum_q, out_sum_d;

    logic start_accept;
    logic feed_ready;
    logic feed_accept;
    logic last_partial;
    logic pipe_in;
    logic pipe_out;

    always_comb begin
        start_accept = (state_q == ST_IDLE) && start && (num_chunks != 4'd0);
        feed_ready   = (state_q == ST_FEED) && (issued_q < n_q);
        feed_accept  = feed_ready && in_valid;
        // The final partial is being written this cycle, so FEED can end now.
        last_partial = (state_q == ST_FEED) && pipe_out && ((received_q + 4'd1) == n_q);
        pipe_in      = feed_accept || (state_q == ST_FOLD);
    end

    reduce_valid_pipe #(
        .DEPTH (TREE_LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_bit  (pipe_in),
        .out_bit (pipe_out)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (last_partial) begin
                    state_d = (n_q == 4'd1) ? ST_DONE : ST_FOLD;
                end
            end
            ST_FOLD: begin
                state_d = ST_FOLD_WAIT;
            end
            ST_FOLD_WAIT: begin
                if (pipe_out) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // datapath next values
    always_comb begin
        n_d        = n_q;
        issued_d   = issued_q;
        received_d = received_q;
        wr_ptr_d   = wr_ptr_q;
        pbuf_d     = pbuf_q;
        out_sum_d  = out_sum_q;

        if (start_accept) begin
            n_d        = clamp_chunks(num_chunks);
            issued_d   = 4'd0;
            received_d = 4'd0;
            wr_ptr_d   = 3'd0;
        end

        if (feed_accept) begin
            issued_d = issued_q + 4'd1;
        end

        if ((state_q == ST_FEED) && pipe_out) begin
            pbuf_d[wr_ptr_q] = tree_sum;
            wr_ptr_d         = wr_ptr_q + 3'd1;
            received_d       = received_q + 4'd1;
        end

        // Single-chunk rows skip the fold; the partial landing in pbuf[0]
        // this cycle is the row sum, so take it straight from tree_sum.
        if (last_partial && (n_q == 4'd1)) begin
            out_sum_d = tree_sum;
        end

        if ((state_q == ST_FOLD_WAIT) && pipe_out) begin
            out_sum_d = tree_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q        <= 4'd0;
            issued_q   <= 4'd0;
            received_q <= 4'd0;
            wr_ptr_q   <= 3'd0;
            out_sum_q  <= '0;
            for (int i = 0; i < MAX_CHUNKS; i++) begin
                pbuf_q[i] <= '0;
            end
        end else begin
            n_q        <= n_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            wr_ptr_q   <= wr_ptr_d;
            out_sum_q  <= out_sum_d;
            pbuf_q     <= pbuf_d;
        end
    end

    // outputs
    always_comb begin
        in_ready  = feed_ready;
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_DONE);
        out_sum   = out_sum_q;
        tree_in   = '0;
        case (state_q)
            ST_FEED: begin
                if (feed_accept) begin
                    tree_in = in_data;
                end
            end
            ST_FOLD: begin
                for (int i = 0; i < LANES; i++) begin
                    tree_in[i*WORD_W +: WORD_W] = (4'(i) < n_q) ? pbuf_q[i] : FP_ZERO;
                end
            end
            default: begin
                tree_in = '0;
            end
        endcase
    end

`ifdef TREE_REDUCE_PERF_EN
    logic [15:0] perf_q, perf_d;
    logic        perf_run_q, perf_run_d;

    // Runs from the cycle after start-accept through the first DONE cycle.
    always_comb begin
        perf_d     = perf_q;
        perf_run_d = perf_run_q;
        if (start_accept) begin
            perf_d     = 16'd0;
            perf_run_d = 1'b1;
        end else if (perf_run_q) begin
            if (perf_q != 16'hFFFF) begin
                perf_d = perf_q + 16'd1;
            end
            if (state_q == ST_DONE) begin
                perf_run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q     <= 16'd0;
            perf_run_q <= 1'b0;
        end else begin
            perf_q     <= perf_d;
            perf_run_q <= perf_run_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'd0;
`endif

endmodule
